sar_scan_sequencer: RTL and testbench
=====================================

// Module: sar_scan_sequencer
// PURPOSE
//  Multi-channel scan controller for the 8-bit SAR converter core.
//  - Walks an enabled-channel mask in ascending order: drives the analog mux select, waits a settle time, pulses the SAR start, then collects code on SAR done.
//  - Stores one result per channel; supports single-scan and continuous modes.
//  - Sits between the host register interface and the SAR core.
// PARAMETERS
//  NUM_CH          4   number of analog channels (2..8)
//  CH_W            2   channel index width, clog2(NUM_CH)
//  SETTLE_CYCLES   4   mux settle cycles before each conversion (>=1)
//  TIMEOUT_CYCLES  32  max CONVERT cycles waiting for sar_done (>=9)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  enable     in   1       0 = abort/hold in IDLE
//  start      in   1       pulse: begin a scan (IDLE only)
//  continuous in   1       1 = restart scan after last channel
//  ch_mask    in   NUM_CH  enabled channels, sampled at scan start
//  clr_err    in   1       pulse: clear err_timeout
//  mux_sel    out  CH_W    analog mux channel select
//  sar_start  out  1       1-cycle pulse to SAR core
//  sar_done   in   1       SAR conversion complete
//  sar_code   in   8       SAR result, valid with sar_done
//  res_valid  out  1       1-cycle strobe: new result stored
//  res_ch     out  CH_W    channel of strobed result
//  res_code   out  8       strobed result value
//  rd_ch      in   CH_W    result read address
//  rd_code    out  8       result[rd_ch], combinational
//  busy       out  1       state != IDLE
//  scan_done  out  1       1-cycle pulse after last channel of a scan
//  err_timeout out 1       sticky: a conversion timed out
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, result array 0, mask snapshot 0.
//  FSM states: IDLE, SETTLE, START, CONVERT.
//  - IDLE -> SETTLE: on start & enable & |ch_mask.
//      Snapshot ch_mask; mux_sel <= lowest set bit; settle counter <= 0.
//      start with a zero mask is ignored.
//  - SETTLE: count SETTLE_CYCLES cycles -> START.
//      sar_done is ignored here.
//  - START: sar_start = 1 for exactly this cycle -> CONVERT.
//      Latency: sar_start is high SETTLE_CYCLES+1 cycles after the start edge.
//  - CONVERT, sar_done = 1 on an edge:
//      result[mux_sel] <= sar_code.
//      Next cycle: res_valid = 1 with res_ch/res_code.
//      Then advance to the next set bit of the snapshot.
//  - CONVERT, TIMEOUT_CYCLES reached without sar_done:
//      err_timeout <= 1; no result written; no res_valid; advance.
//  Advance rule:
//  - Next higher set bit exists -> SETTLE with new mux_sel.
//  - Otherwise scan_done pulses, then:
//      continuous = 1 -> re-snapshot ch_mask, SETTLE at its lowest bit.
//      If the new mask is 0 -> IDLE.
//      continuous = 0 -> IDLE.
//  Boundaries:
//  - ch_mask change mid-scan: no effect until the next snapshot.
//  - start while busy: ignored.
//  - continuous dropped mid-scan: current scan finishes, then IDLE.
//  - enable = 0 in any state: IDLE next edge; sar_start forced 0 that cycle; no res_valid; results retained.
//  - clr_err on the same edge as a new timeout: set wins.
//  - Single-channel mask: the same channel is reconverted each pass in continuous mode.
//  - mux_sel holds its value in IDLE.
// STRUCTURE
//  sar_scan_pkg holds:
//  - state_t enum (IDLE, SETTLE, START, CONVERT)
//  - localparams CODE_W = 8 and counter widths from the parameters.
//  Sub-module sar_next_ch (combinational):
//  - Finds the next set bit above the current index, or the lowest set bit.
//  - Returns a found flag.
//  Top-level owns the FSM, counters, result register array and strobes.
// TESTING
//  - Reset mid-CONVERT:
//      stimulus: rst_n low.
//      response: all outputs 0 immediately; rd_code 0 for every channel.
//  - Mask 4'b0101, start, SAR model answers codes 8'h3C and 8'hA5:
//      res_valid on ch0 = 8'h3C, then on ch2 = 8'hA5.
//      scan_done pulses once; busy 0 afterwards.
//      sar_start fires SETTLE_CYCLES+1 cycles after start.
//  - Continuous, mask 4'b1000; drop continuous after 3 results:
//      exactly 3 or 4 results on ch3, then IDLE; no mux_sel change.
//  - SAR model never asserts done, mask 4'b0011:
//      err_timeout = 1 after 32 CONVERT cycles; no res_valid.
//      ch1 is attempted; clr_err clears the flag.
//  - Mask 4'b0000 start, and start while busy:
//      both ignored; busy and sequence unaffected.
//  - enable low during SETTLE of ch1:
//      IDLE next cycle, no sar_start.
//      Prior ch0 result is still readable via rd_ch.

Source files
------------

// File: rtl/sar_scan_pkg.sv
// sar_scan_pkg: shared types and constants for the SAR scan sequencer.
//   state_t : scan FSM states
//   CODE_W  : SAR result width
//   cnt_w() : counter width needed to count 0..n-1 (minimum 1 bit)
package sar_scan_pkg;

  localparam int CODE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    START   = 2'd2,
    CONVERT = 2'd3
  } state_t;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sar_scan_sequencer_if.sv
// sar_scan_sequencer_if: link between the scan sequencer and the SAR core.
//   mux_sel   : analog mux channel select (sequencer -> core)
//   sar_start : 1-cycle conversion start pulse (sequencer -> core)
//   sar_done  : conversion complete (core -> sequencer)
//   sar_code  : conversion result, valid with sar_done (core -> sequencer)
// master = sequencer side, slave = SAR core side.
interface sar_scan_sequencer_if #(
  parameter int CH_W = 2
);
  import sar_scan_pkg::*;

  logic [CH_W-1:0]   mux_sel;
  logic              sar_start;
  logic              sar_done;
  logic [CODE_W-1:0] sar_code;

  modport master (output mux_sel, sar_start, input  sar_done, sar_code);
  modport slave  (input  mux_sel, sar_start, output sar_done, sar_code);

endinterface

// File: rtl/sar_next_ch.sv
// sar_next_ch: combinational channel picker.
//   mask   : enabled channels
//   cur    : current channel index
//   lowest : 1 = return the lowest set bit, 0 = next set bit strictly above cur
//   nxt    : selected channel
//   found  : a qualifying bit exists
module sar_next_ch #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  input  logic              lowest,
  output logic [CH_W-1:0]   nxt,
  output logic              found
);

  // Descending walk: the last qualifying hit is the lowest one.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (lowest || (i > int'(cur)))) begin
        nxt   = CH_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sar_scan_sequencer.sv
// sar_scan_sequencer: multi-channel scan controller for the 8-bit SAR core.
// Walks a snapshot of ch_mask in ascending order: select mux, settle,
// pulse sar_start, collect sar_code on sar_done; one result per channel.
//   clk, rst_n        : clock, async active-low reset
//   enable            : 0 forces IDLE
//   start, continuous : scan control; ch_mask sampled at each scan start
//   clr_err           : clears sticky err_timeout (a new timeout wins)
//   sar               : mux select / start / done / code to the SAR core
//   res_valid/ch/code : 1-cycle strobe of each stored result
//   rd_ch, rd_code    : combinational result readback
//   busy, scan_done, err_timeout : status
module sar_scan_sequencer
  import sar_scan_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CH_W           = 2,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     start,
  input  logic                     continuous,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic                     clr_err,
  sar_scan_sequencer_if.master     sar,
  output logic                     res_valid,
  output logic [CH_W-1:0]          res_ch,
  output logic [CODE_W-1:0]        res_code,
  input  logic [CH_W-1:0]          rd_ch,
  output logic [CODE_W-1:0]        rd_code,
  output logic                     busy,
  output logic                     scan_done,
  output logic                     err_timeout
);

  localparam int SCNT_W = cnt_w(SETTLE_CYCLES);
  localparam int TCNT_W = cnt_w(TIMEOUT_CYCLES);

  state_t                          state_q, state_d;
  logic [NUM_CH-1:0]               mask_q, mask_d;
  logic [CH_W-1:0]                 mux_sel_q, mux_sel_d;
  logic [SCNT_W-1:0]               scnt_q, scnt_d;
  logic [TCNT_W-1:0]               tcnt_q, tcnt_d;
  logic [NUM_CH-1:0][CODE_W-1:0]   res_q, res_d;
  logic [CH_W-1:0]                 res_ch_q, res_ch_d;
  logic [CODE_W-1:0]               res_code_q, res_code_d;
  logic                            res_valid_q, res_valid_d;
  logic                            scan_done_q, scan_done_d;
  logic                            err_q, err_d;

  logic [CH_W-1:0]                 nxt_ch, low_ch;
  logic                            nxt_found, low_found;
  logic                            adv;

  // Next channel above the current one within the scan snapshot.
  sar_next_ch #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_nxt (
    .mask(mask_q), .cur(mux_sel_q), .lowest(1'b0), .nxt(nxt_ch), .found(nxt_found)
  );

  // Lowest channel of the live mask, used for every (re)snapshot.
  sar_next_ch #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_low (
    .mask(ch_mask), .cur('0), .lowest(1'b1), .nxt(low_ch), .found(low_found)
  );

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    mux_sel_d   = mux_sel_q;
    scnt_d      = scnt_q;
    tcnt_d      = tcnt_q;
    res_d       = res_q;
    res_ch_d    = res_ch_q;
    res_code_d  = res_code_q;
    res_valid_d = 1'b0;
    scan_done_d = 1'b0;
    err_d       = err_q & ~clr_err;
    adv         = 1'b0;

    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start && low_found) begin
          mask_d    = ch_mask;
          mux_sel_d = low_ch;
          scnt_d    = '0;
          state_d   = SETTLE;
        end
        SETTLE: begin
          if (scnt_q == SCNT_W'(SETTLE_CYCLES - 1)) state_d = START;
          else                                      scnt_d  = scnt_q + SCNT_W'(1);
        end
        START: begin
          tcnt_d  = '0;
          state_d = CONVERT;
        end
        CONVERT: begin
          if (sar.sar_done) begin
            res_d[mux_sel_q] = sar.sar_code;
            res_valid_d      = 1'b1;
            res_ch_d         = mux_sel_q;
            res_code_d       = sar.sar_code;
            adv              = 1'b1;
          end else if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
            err_d = 1'b1;
            adv   = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Channel finished (result or timeout): next snapshot bit, or end of scan.
    if (adv) begin
      scnt_d = '0;
      if (nxt_found) begin
        mux_sel_d = nxt_ch;
        state_d   = SETTLE;
      end else begin
        scan_done_d = 1'b1;
        if (continuous && low_found) begin
          mask_d    = ch_mask;
          mux_sel_d = low_ch;
          state_d   = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      mux_sel_q   <= '0;
      scnt_q      <= '0;
      tcnt_q      <= '0;
      res_q       <= '0;
      res_ch_q    <= '0;
      res_code_q  <= '0;
      res_valid_q <= 1'b0;
      scan_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      mux_sel_q   <= mux_sel_d;
      scnt_q      <= scnt_d;
      tcnt_q      <= tcnt_d;
      res_q       <= res_d;
      res_ch_q    <= res_ch_d;
      res_code_q  <= res_code_d;
      res_valid_q <= res_valid_d;
      scan_done_q <= scan_done_d;
      err_q       <= err_d;
    end
  end

  // enable gates sar_start so a disable in START never launches a conversion.
  assign sar.mux_sel   = mux_sel_q;
  assign sar.sar_start = (state_q == START) && enable;
  assign res_valid     = res_valid_q;
  assign res_ch        = res_ch_q;
  assign res_code      = res_code_q;
  assign rd_code       = res_q[rd_ch];
  assign busy          = (state_q != IDLE);
  assign scan_done     = scan_done_q;
  assign err_timeout   = err_q;

endmodule

// File: tb/tb_sar_scan_sequencer.sv
module tb_sar_scan_sequencer;
  localparam int NUM_CH  = 4;
  localparam int CH_W    = 2;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 32;

  logic clk = 1'b0;
  logic rst_n, enable, start, continuous, clr_err;
  logic [NUM_CH-1:0] ch_mask;
  logic [CH_W-1:0]   rd_ch, res_ch;
  logic [7:0]        res_code, rd_code;
  logic              res_valid, busy, scan_done, err_timeout;

  sar_scan_sequencer_if #(.CH_W(CH_W)) sar ();

  sar_scan_sequencer #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .continuous(continuous),
    .ch_mask(ch_mask), .clr_err(clr_err), .sar(sar), .res_valid(res_valid),
    .res_ch(res_ch), .res_code(res_code), .rd_ch(rd_ch), .rd_code(rd_code),
    .busy(busy), .scan_done(scan_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // SAR core model: answers done with code_tab[mux_sel] two cycles after sar_start.
  logic [7:0] code_tab [NUM_CH];
  logic       sar_mute;
  int         cd = 0;
  always @(negedge clk) begin
    sar.sar_done = 1'b0;
    if (!rst_n) begin
      cd = 0;
      sar.sar_code = 8'h00;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          sar.sar_done = 1'b1;
          sar.sar_code = code_tab[sar.mux_sel];
        end
      end
      if (sar.sar_start && !sar_mute) cd = 2;
    end
  end

  // Event log, sampled just after each rising edge.
  logic [CH_W-1:0] rch [$];
  logic [7:0]      rcode [$];
  int ndone = 0, nstart = 0;
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (res_valid) begin
        rch.push_back(res_ch);
        rcode.push_back(res_code);
      end
      if (scan_done) ndone++;
      if (sar.sar_start) nstart++;
    end
  end

  task automatic go(input logic [NUM_CH-1:0] m);
    ch_mask = m;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic wait_sar_start(input int max, output int n);
    n = 0;
    while (!sar.sar_start && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, b0, d0, s0, k, ok;
    rst_n = 1'b0; enable = 1'b1; start = 1'b0; continuous = 1'b0;
    ch_mask = '0; clr_err = 1'b0; rd_ch = '0; sar_mute = 1'b0;
    code_tab = '{8'h3C, 8'h11, 8'hA5, 8'hC3};
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_sel", sar.mux_sel, 0);
    chk("rst_start", sar.sar_start, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_err", err_timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Mask 0101 with start-while-busy and mid-scan mask change
    b0 = rch.size(); d0 = ndone; s0 = nstart;
    go(4'b0101);
    wait_sar_start(20, n);
    chk("a_start_lat", n, SETTLE);
    chk("a_sel0", sar.mux_sel, 0);
    ch_mask = 4'b1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("a_busy", busy, 1);
    wait_idle(200, "a_idle");
    @(negedge clk);
    chk("a_nres", rch.size() - b0, 2);
    chk("a_ch0", rch[b0], 0);
    chk("a_code0", rcode[b0], 8'h3C);
    chk("a_ch2", rch[b0+1], 2);
    chk("a_code2", rcode[b0+1], 8'hA5);
    chk("a_done", ndone - d0, 1);
    chk("a_nstart", nstart - s0, 2);
    rd_ch = 2'd2; #1;
    chk("a_rd2", rd_code, 8'hA5);
    rd_ch = 2'd1; #1;
    chk("a_rd1", rd_code, 8'h00);

    // Zero-mask start is ignored
    s0 = nstart;
    go(4'b0000);
    repeat (2) @(negedge clk);
    chk("z_busy", busy, 0);
    chk("z_nstart", nstart - s0, 0);

    // Continuous single channel, drop continuous after 3 results
    b0 = rch.size(); d0 = ndone; ok = 0;
    continuous = 1'b1;
    go(4'b1000);
    n = 0;
    while ((rch.size() - b0) < 3 && n < 300) begin
      if (sar.mux_sel != 2'd3) ok++;
      @(negedge clk);
      n++;
    end
    continuous = 1'b0;
    wait_idle(100, "b_idle");
    @(negedge clk);
    k = rch.size() - b0;
    chk("b_n34", (k == 3 || k == 4), 1);
    chk("b_selbad", ok, 0);
    ok = 1;
    for (int i = b0; i < rch.size(); i++)
      if (rch[i] != 2'd3 || rcode[i] != 8'hC3) ok = 0;
    chk("b_ch3", ok, 1);
    chk("b_done", ndone - d0, k);
    chk("b_sel", sar.mux_sel, 3);

    // Timeout: SAR never answers, mask 0011
    sar_mute = 1'b1;
    b0 = rch.size(); d0 = ndone; s0 = nstart;
    go(4'b0011);
    wait_sar_start(20, n);
    n = 0;
    while (!err_timeout && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("c_to_lat", n, TIMEOUT + 1);
    chk("c_sel1", sar.mux_sel, 1);
    clr_err = 1'b1;
    @(negedge clk);
    chk("c_clr", err_timeout, 0);
    // clr_err held through ch1's timeout: the new timeout must still set the flag
    wait_idle(100, "c_idle");
    chk("c_setwins", err_timeout, 1);
    clr_err = 1'b0;
    @(negedge clk);
    chk("c_sticky", err_timeout, 1);
    chk("c_nres", rch.size() - b0, 0);
    chk("c_done", ndone - d0, 1);
    chk("c_nstart", nstart - s0, 2);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("c_clr2", err_timeout, 0);
    sar_mute = 1'b0;

    // enable low during SETTLE of ch1
    code_tab[0] = 8'h5A;
    b0 = rch.size();
    go(4'b0011);
    n = 0;
    while ((rch.size() - b0) < 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("d_sel1", sar.mux_sel, 1);
    enable = 1'b0;
    s0 = nstart;
    @(negedge clk);
    chk("d_idle", busy, 0);
    repeat (8) @(negedge clk);
    chk("d_nstart", nstart - s0, 0);
    chk("d_nres", rch.size() - b0, 1);
    rd_ch = 2'd0; #1;
    chk("d_rd0", rd_code, 8'h5A);
    enable = 1'b1;

    // Reset mid-CONVERT
    sar_mute = 1'b1;
    go(4'b0100);
    wait_sar_start(20, n);
    repeat (2) @(negedge clk);
    chk("e_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("e_busy", busy, 0);
    chk("e_sel", sar.mux_sel, 0);
    chk("e_start", sar.sar_start, 0);
    chk("e_valid", res_valid, 0);
    chk("e_rch", res_ch, 0);
    chk("e_rcode", res_code, 0);
    chk("e_done", scan_done, 0);
    chk("e_err", err_timeout, 0);
    for (int c = 0; c < NUM_CH; c++) begin
      rd_ch = CH_W'(c); #1;
      chk("e_rd", rd_code, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sar_mute = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
